// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the adder streaming front end.
package adder_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        CAPTURE = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    function automatic int beats(input int n, input int w);
        return n / w;
    endfunction

    // Beat index width; a single-beat operand still needs a 1-bit counter.
    function automatic int cntw(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/adder_stream_frontend_if.sv
// Operand beat stream in, registered sum stream out.
interface adder_stream_frontend_if #(
    parameter int N = 16,
    parameter int W = 8
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_sum;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_sum, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_sum, out_valid
    );
endinterface

// File: rtl/operand_deserializer.sv
// N-bit operand register filled one W-bit chunk at a time; unwritten chunks hold.
module operand_deserializer
    import adder_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 8,
    localparam int K  = beats(N, W),
    localparam int CW = cntw(K)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [CW-1:0] idx,
    input  logic [W-1:0]  data,
    output logic [N-1:0]  q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < K; i++) begin
                if (idx == CW'(i)) q[i*W +: W] <= data;
            end
        end
    end

endmodule

// File: rtl/adder_stream_frontend.sv
// Deserializes two operands onto an external adder and returns its sum as a stream.
//
// state   | meaning
// LOAD_A  | accepting beats of operand A into x1
// LOAD_B  | accepting beats of operand B into x2
// CAPTURE | x1/x2 stable, register adder y into out_sum
// OUTPUT  | holding out_sum valid until out_ready
module adder_stream_frontend
    import adder_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    adder_stream_frontend_if.slave    strm,
    output logic [N-1:0]              x1,
    output logic [N-1:0]              x2,
    input  logic [N-1:0]              y,
    output logic                      busy
);

    localparam int K  = beats(N, W);
    localparam int CW = cntw(K);
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    generate
        if ((N % W) != 0 || N < W) begin : g_bad_width
            $error("adder_stream_frontend: N must be a non-zero multiple of W");
        end
    endgenerate

    state_t        state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          last_beat;

    assign strm.in_ready = (state == LOAD_A) || (state == LOAD_B);
    assign accept        = strm.in_valid && strm.in_ready;
    assign last_beat     = (cnt == LAST);
    assign busy          = (state != LOAD_A) || (cnt != '0);

    operand_deserializer #(.N(N), .W(W)) u_deser_a (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (accept && (state == LOAD_A)),
        .idx   (cnt),
        .data  (strm.in_data),
        .q     (x1)
    );

    operand_deserializer #(.N(N), .W(W)) u_deser_b (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (accept && (state == LOAD_B)),
        .idx   (cnt),
        .data  (strm.in_data),
        .q     (x2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= LOAD_A;
            cnt            <= '0;
            strm.out_sum   <= '0;
            strm.out_valid <= 1'b0;
        end else begin
            case (state)
                LOAD_A, LOAD_B: begin
                    if (accept) begin
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= (state == LOAD_A) ? LOAD_B : CAPTURE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    strm.out_sum   <= y;
                    strm.out_valid <= 1'b1;
                    state          <= OUTPUT;
                end
                OUTPUT: begin
                    // A beat offered on the completing edge is refused; in_ready is still low.
                    if (strm.out_ready) begin
                        strm.out_valid <= 1'b0;
                        state          <= LOAD_A;
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_stream_frontend.sv
// Directed bench for adder_stream_frontend with a behavioural adder closing the loop.
module tb_adder_stream_frontend;
    localparam int N = 16;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] x1, x2, y;
    logic         busy;
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    int           rise1 = 0;

    always #5 clk = ~clk;

    adder_stream_frontend_if #(.N(N), .W(W)) bus ();

    assign y = x1 + x2;

    adder_stream_frontend #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .strm  (bus),
        .x1    (x1),
        .x2    (x2),
        .y     (y),
        .busy  (busy)
    );

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [W-1:0] b);
        bit ok;
        ok = 1'b0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: beat %h never accepted", b);
        end
    endtask

    task automatic send_op(input logic [N-1:0] a, input logic [N-1:0] b);
        send(a[7:0]);
        send(a[15:8]);
        send(b[7:0]);
        send(b[15:8]);
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] exp, input string tag);
        send_op(a, b);
        tick();
        check({tag, "_valid"}, bus.out_valid, 1'b1);
        check({tag, "_sum"}, bus.out_sum, exp);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_done"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_x1", x1, 16'h0000);
        check("rst_x2", x2, 16'h0000);
        check("rst_sum", bus.out_sum, 16'h0000);
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        // Basic sum 0x1234 + 0x0F0F
        send(8'h34);
        send(8'h12);
        send(8'h0F);
        check("t1_x1", x1, 16'h1234);
        check("t1_busy", busy, 1'b1);
        send(8'h0F);
        check("t1_x2", x2, 16'h0F0F);
        check("t1_capture_valid", bus.out_valid, 1'b0);
        check("t1_capture_ready", bus.in_ready, 1'b0);
        tick();
        check("t1_valid", bus.out_valid, 1'b1);
        check("t1_sum", bus.out_sum, 16'h2143);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t1_done_valid", bus.out_valid, 1'b0);
        check("t1_done_ready", bus.in_ready, 1'b1);
        check("t1_done_busy", busy, 1'b0);
        check("t1_sum_hold", bus.out_sum, 16'h2143);

        // Wrap-around
        run_op(16'hFFFF, 16'h0001, 16'h0000, "t2a");
        run_op(16'h8000, 16'h8000, 16'h0000, "t2b");

        // Backpressure with ignored beats
        send_op(16'h4321, 16'h0101);
        tick();
        check("t3_valid", bus.out_valid, 1'b1);
        check("t3_sum", bus.out_sum, 16'h4422);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_bp_sum", bus.out_sum, 16'h4422);
            check("t3_bp_valid", bus.out_valid, 1'b1);
            check("t3_bp_ready", bus.in_ready, 1'b0);
        end
        bus.in_valid = 1'b0;
        check("t3_x1_kept", x1, 16'h4321);
        check("t3_x2_kept", x2, 16'h0101);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t3_done", bus.out_valid, 1'b0);
        tick();
        tick();
        check("t3_single", bus.out_valid, 1'b0);
        check("t3_idle", busy, 1'b0);

        // Input gaps: 1,0,0,1,0,1,1
        bus.in_valid = 1'b1; bus.in_data = 8'hCD; tick();
        check("t4_partial", x1, 16'h43CD);
        check("t4_busy", busy, 1'b1);
        bus.in_valid = 1'b0; tick(); tick();
        check("t4_gap_x1", x1, 16'h43CD);
        check("t4_gap_busy", busy, 1'b1);
        bus.in_valid = 1'b1; bus.in_data = 8'hAB; tick();
        check("t4_x1", x1, 16'hABCD);
        bus.in_valid = 1'b0; tick();
        bus.in_valid = 1'b1; bus.in_data = 8'h11; tick();
        check("t4_x2_partial", x2, 16'h0111);
        tick();
        bus.in_valid = 1'b0;
        check("t4_x2", x2, 16'h1111);
        check("t4_capture", bus.out_valid, 1'b0);
        tick();
        check("t4_sum", bus.out_sum, 16'hBCDE);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Reset mid-load
        send(8'h55);
        send(8'h66);
        send(8'h77);
        check("t5_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_x1", x1, 16'h0000);
        check("t5_x2", x2, 16'h0000);
        check("t5_busy_rst", busy, 1'b0);
        check("t5_ready", bus.in_ready, 1'b1);
        check("t5_valid", bus.out_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        run_op(16'h0002, 16'h0003, 16'h0005, "t5");

        // Reset drops a pending result asynchronously
        send_op(16'h0001, 16'h0001);
        tick();
        check("t5b_pending", bus.out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5b_valid_drop", bus.out_valid, 1'b0);
        check("t5b_sum_clear", bus.out_sum, 16'h0000);
        tick();
        rst_n = 1'b1;

        // Back-to-back with out_ready tied high
        bus.out_ready = 1'b1;
        send_op(16'h0001, 16'h0002);
        tick();
        check("t6a_valid", bus.out_valid, 1'b1);
        check("t6a_sum", bus.out_sum, 16'h0003);
        rise1 = cyc;
        tick();
        check("t6a_one_cycle", bus.out_valid, 1'b0);
        check("t6a_ready", bus.in_ready, 1'b1);
        send_op(16'h7FFF, 16'h0001);
        tick();
        check("t6b_valid", bus.out_valid, 1'b1);
        check("t6b_sum", bus.out_sum, 16'h8000);
        check("t6_spacing", 16'(cyc - rise1), 16'd6);
        tick();
        check("t6b_one_cycle", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
